apple2_bus_host: RTL and testbench
==================================

// Module: apple2_bus_host
// PURPOSE
//  Apple II host-side bus initiator: the motherboard end of the slot protocol our card logic answers.
//  Derives PHI0/PHI1 from C7M and drives A, nWE, D and the slot selects (nDEVSEL/nIOSEL/nIOSTRB) for one slot.
//  Executes single-byte read/write commands from a valid/ready port, returns read data.
//  Used as bench/bring-up master for card CPLDs and as a 6502-less test host.
// PARAMETERS
//  SLOT          4   slot number 1..7; sets DEVSEL/IOSEL decode
//  RESET_CYCLES  16  bus cycles nRES is held low after RES
// PORTS
//  C7M        in   1   7 MHz clock, all logic on posedge
//  RES        in   1   synchronous, active-high reset
//  PHI0       out  1   6502 phase 0 (high = data phase)
//  PHI1       out  1   ~PHI0
//  nRES       out  1   slot reset, active low
//  A          out  16  address bus
//  nWE        out  1   R/W, low = write
//  D          inout 8  data bus; driven only in write data phase
//  nDEVSEL    out  1   low for A in C080+SLOT*16 .. +0xF
//  nIOSEL     out  1   low for A in C000+SLOT*256 .. +0xFF (Cn00-CnFF)
//  nIOSTRB    out  1   low for A in C800..CFFF
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted this clock if cmd_valid
//  cmd_addr   in   16  address
//  cmd_we     in   1   1 = write
//  cmd_wdata  in   8   write data
//  rsp_valid  out  1   one-clock pulse, read data valid
//  rsp_rdata  out  8   read data
// BEHAVIOUR
//  - Reset: phase P=0, PHI1=1, PHI0=0, nRES=0, A=0000, nWE=1, D=Z, all selects=1, cmd_ready=0,
//    rsp_valid=0, rsp_rdata=00. Reset mid-cycle aborts the cycle; no rsp_valid for it.
//  - Bus cycle = 7 C7M clocks, P=0..6. PHI1=1 for P0-P3, PHI0=1 for P4-P6; both registered, glitch-free.
//  - A, nWE latched at the P6->P0 edge and held the whole cycle. Selects decoded from the latched A,
//    asserted (low) only in P4-P6, deasserted at the P6->P0 edge.
//  - Write: D driven with wdata in P4-P6 only; Z otherwise. Read: D sampled at the P6->P0 edge;
//    rsp_rdata updated and rsp_valid=1 for that clock (P0 of next cycle). Writes give no rsp_valid.
//  - cmd_ready = 1 only when P==6 and nRES==1. Accept = cmd_valid & cmd_ready; that command runs in the
//    next cycle, so back-to-back commands fill consecutive bus cycles. Read latency: accept -> rsp_valid
//    = 8 clocks (one long cycle: 9).
//  - No accepted command: idle cycle with A=0000, nWE=1, no select, D=Z, no rsp_valid.
//  - nRES: low for RESET_CYCLES full bus cycles after RES falls, released at a P6->P0 edge.
//    Only idle cycles until then.
//  - Decode precedence: nDEVSEL and nIOSEL exclusive by address. nIOSTRB independent, C800-CFFF.
//    CFFF asserts nIOSTRB like any C8xx address.
//  - Counters wrap: phase 6->0; reset-cycle counter saturates at RESET_CYCLES.
// CONFIGURATION
//  APPLE2_LONG_CYCLE_EN defined: every 65th bus cycle (cycle counter 0..64, cycle 64) is long.
//    A second P3 clock is inserted (PHI1 high 5 clocks, cycle = 8 clocks).
//    Select and data timing stays relative to P4-P6. The counter resets with RES.
//  Undefined: all cycles 7 clocks, no cycle counter.
// TESTING
//  1 RES 3 clocks then low -> nRES low 16*7=112 clocks; cmd_ready stays 0 meanwhile; PHI0 period 7,
//    high 3 clocks.
//  2 SLOT=4, write C0C3<=5A -> nDEVSEL low P4-P6 only; nWE low whole cycle; D=5A P4-P6, Z elsewhere;
//    no rsp_valid.
//  3 Read C400, card model drives A7 in PHI0 -> nIOSEL low P4-P6; rsp_valid once, rsp_rdata=A7,
//    8 clocks after accept.
//  4 Back-to-back reads C800, CFFF, 0000 with cmd_valid held -> three consecutive cycles; nIOSTRB low
//    in first two; no select in third; three rsp_valid pulses 7 clocks apart.
//  5 RES asserted at P5 of a write to C0C0 -> nDEVSEL and D released next clock; no rsp_valid;
//    nRES low again.
//  6 APPLE2_LONG_CYCLE_EN, idle 130 cycles -> cycles 64 and 129 are 8 clocks, others 7; undefined:
//    all 7.

Source files
------------

// File: rtl/apple2_bus_host.sv
// apple2_bus_host: Apple II motherboard-side slot initiator (PHI0/PHI1, A, nWE, D, slot selects).
// Optional APPLE2_LONG_CYCLE_EN stretches every 65th bus cycle with a second P3 clock.
module apple2_bus_host #(
    parameter int SLOT         = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic        C7M,
    input  logic        RES,
    output logic        PHI0,
    output logic        PHI1,
    output logic        nRES,
    output logic [15:0] A,
    output logic        nWE,
    inout  wire  [7:0]  D,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata
);
    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6} phase_t;

    localparam int          RW       = $clog2(RESET_CYCLES + 1);
    localparam logic [11:0] DEV_PAGE = 12'(12'hC08 + SLOT);
    localparam logic [7:0]  IO_PAGE  = 8'(8'hC0 + SLOT);

    phase_t        p, p_n;
    logic          wrap, accept, data_phase_n;
    logic [RW-1:0] rcnt;
    logic [7:0]    wdata;
    logic          rd_cycle, d_oe;
    logic          hit_dev, hit_io, hit_strb;

`ifdef APPLE2_LONG_CYCLE_EN
    logic [6:0] cyc;
    logic       stretch, stretch_n;
`endif

    assign wrap      = (p == P6);
    assign cmd_ready = wrap && nRES;
    assign accept    = cmd_valid && cmd_ready;
    assign D         = d_oe ? wdata : 'z;

    assign hit_dev  = (A[15:4] == DEV_PAGE);
    assign hit_io   = (A[15:8] == IO_PAGE);
    assign hit_strb = (A[15:11] == 5'b11001);

    always_comb begin
        p_n          = p;
        data_phase_n = 1'b0;
`ifdef APPLE2_LONG_CYCLE_EN
        stretch_n    = stretch;
`endif
        case (p)
            P0: p_n = P1;
            P1: p_n = P2;
            P2: p_n = P3;
`ifdef APPLE2_LONG_CYCLE_EN
            P3: begin
                if (cyc == 7'd64 && !stretch) begin
                    p_n       = P3;
                    stretch_n = 1'b1;
                end else begin
                    p_n       = P4;
                    stretch_n = 1'b0;
                end
            end
`else
            P3: p_n = P4;
`endif
            P4: p_n = P5;
            P5: p_n = P6;
            P6: p_n = P0;
            default: p_n = P0;
        endcase
        data_phase_n = (p_n == P4) || (p_n == P5) || (p_n == P6);
    end

    // All bus outputs are registered from the next phase so they change only on C7M edges.
    always_ff @(posedge C7M) begin
        if (RES) begin
            p         <= P0;
            PHI1      <= 1'b1;
            PHI0      <= 1'b0;
            nRES      <= 1'b0;
            rcnt      <= '0;
            A         <= '0;
            nWE       <= 1'b1;
            wdata     <= '0;
            rd_cycle  <= 1'b0;
            d_oe      <= 1'b0;
            nDEVSEL   <= 1'b1;
            nIOSEL    <= 1'b1;
            nIOSTRB   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            p         <= p_n;
            PHI1      <= !data_phase_n;
            PHI0      <= data_phase_n;
            rsp_valid <= 1'b0;
            if (wrap) begin
                if (rd_cycle) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= D;
                end
                A        <= accept ? cmd_addr : '0;
                nWE      <= !(accept && cmd_we);
                wdata    <= cmd_wdata;
                rd_cycle <= accept && !cmd_we;
                if (!nRES) begin
                    if (rcnt == RW'(RESET_CYCLES - 1))
                        nRES <= 1'b1;
                    rcnt <= rcnt + 1'b1;
                end
            end
            d_oe    <= data_phase_n && !nWE;
            nDEVSEL <= !(data_phase_n && hit_dev);
            nIOSEL  <= !(data_phase_n && hit_io);
            nIOSTRB <= !(data_phase_n && hit_strb);
        end
    end

`ifdef APPLE2_LONG_CYCLE_EN
    always_ff @(posedge C7M) begin
        if (RES) begin
            cyc     <= '0;
            stretch <= 1'b0;
        end else begin
            stretch <= stretch_n;
            if (wrap)
                cyc <= (cyc == 7'd64) ? 7'd0 : cyc + 7'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apple2_bus_host.sv
// Bench for apple2_bus_host: directed scenarios plus randomized traffic against a card model.
module tb_apple2_bus_host;
    localparam int SLOT     = 4;
    localparam int RC       = 16;
    localparam int RST_CLKS = RC * 7;
`ifdef APPLE2_LONG_CYCLE_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    logic        C7M = 1'b0;
    logic        RES, cmd_valid, cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        PHI0, PHI1, nRES, nWE, nDEVSEL, nIOSEL, nIOSTRB, cmd_ready, rsp_valid;
    logic [15:0] A;
    logic [7:0]  rsp_rdata;
    wire  [7:0]  D;

    int checks = 0;
    int errors = 0;
    int t = 0;

    apple2_bus_host #(.SLOT(SLOT), .RESET_CYCLES(RC)) dut (
        .C7M(C7M), .RES(RES), .PHI0(PHI0), .PHI1(PHI1), .nRES(nRES), .A(A), .nWE(nWE), .D(D),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 C7M = ~C7M;

    // clocks elapsed since the last reset edge
    always @(posedge C7M) begin
        if (RES) t <= 0;
        else     t <= t + 1;
    end

    // Undriven bus floats to FF; the card answers reads whenever PHI0 is high with nWE high.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (D[i]);
    end

    logic [7:0] card_idx, card_q;
    logic       card_flag [256];
    logic [7:0] card_val  [256];
    assign card_idx = A[7:0] ^ A[15:8];
    assign card_q   = card_flag[card_idx] ? card_val[card_idx] : (card_idx ^ 8'h63);
    assign D        = (PHI0 && nWE) ? card_q : 8'hzz;

    always @(posedge C7M) begin
        if (RES) begin
            for (int i = 0; i < 256; i++) card_flag[i] <= 1'b0;
        end else if (PHI0 && !nWE) begin
            card_flag[card_idx] <= 1'b1;
            card_val[card_idx]  <= D;
        end
    end

    // Reference phase from elapsed clocks: 65-cycle frames of 456 clocks when long cycles exist.
    function automatic int phase_of(int tt);
        int u;
        if (!LONG) return tt % 7;
        u = tt % 456;
        if (u < 448) return u % 7;
        u = u - 448;
        return (u <= 3) ? u : u - 1;
    endfunction

    function automatic bit exp_ready();
        return (phase_of(t) == 6) && (t >= RST_CLKS);
    endfunction

    // {nDEVSEL, nIOSEL, nIOSTRB} expected for address a in phase ph
    function automatic logic [2:0] exp_sel(logic [15:0] a, int ph);
        int ai;
        bit act;
        ai = int'(a);
        act = (ph >= 4);
        exp_sel[2] = !(act && ai >= 'hC080 + SLOT * 16 && ai <= 'hC08F + SLOT * 16);
        exp_sel[1] = !(act && ai >= 'hC000 + SLOT * 256 && ai <= 'hC0FF + SLOT * 256);
        exp_sel[0] = !(act && ai >= 'hC800 && ai <= 'hCFFF);
    endfunction

    task automatic tick();
        @(posedge C7M);
        @(negedge C7M);
    endtask

    task automatic do_reset(int n);
        RES = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) tick();
        RES = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!exp_ready() && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready got %b want 1 (t=%0d)", cmd_ready, t);
        end
    endtask

    task automatic test_reset();
        int low = 0;
        int ph;
        RES = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({PHI1, PHI0, nRES, nWE, nDEVSEL, nIOSEL, nIOSTRB, cmd_ready, rsp_valid} !== 9'b100111100) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 100111100",
                     {PHI1, PHI0, nRES, nWE, nDEVSEL, nIOSEL, nIOSTRB, cmd_ready, rsp_valid});
        end
        checks++;
        if ({A, rsp_rdata, D} !== {16'h0000, 8'h00, 8'hFF}) begin
            errors++;
            $display("FAIL reset_data got %h want 000000ff", {A, rsp_rdata, D});
        end
        RES = 1'b0;
        for (int i = 0; i < 140; i++) begin
            ph = phase_of(t);
            checks++;
            if ({nRES, cmd_ready, PHI0, PHI1} !== {t >= RST_CLKS, ph == 6 && t >= RST_CLKS, ph >= 4, ph < 4}) begin
                errors++;
                $display("FAIL reset_seq t=%0d got %b want %b", t, {nRES, cmd_ready, PHI0, PHI1},
                         {t >= RST_CLKS, ph == 6 && t >= RST_CLKS, ph >= 4, ph < 4});
            end
            if (!nRES) low++;
            tick();
        end
        checks++;
        if (low != RST_CLKS) begin
            errors++;
            $display("FAIL nres_low_clocks got %0d want %0d", low, RST_CLKS);
        end
    endtask

    task automatic test_write();
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = 16'hC0C3; cmd_we = 1'b1; cmd_wdata = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({nDEVSEL, nIOSEL, nIOSTRB} !== {k < 4, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL write_sel P%0d got %b want %b", k, {nDEVSEL, nIOSEL, nIOSTRB}, {k < 4, 2'b11});
            end
            checks++;
            if ({A, nWE, rsp_valid} !== {16'hC0C3, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL write_bus P%0d got %h/%b/%b want c0c3/0/0", k, A, nWE, rsp_valid);
            end
            checks++;
            if (D !== ((k >= 4) ? 8'h5A : 8'hFF)) begin
                errors++;
                $display("FAIL write_d P%0d got %h want %h", k, D, (k >= 4) ? 8'h5A : 8'hFF);
            end
            tick();
        end
        checks++;
        if ({nDEVSEL, nWE, rsp_valid, D, A} !== {1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000}) begin
            errors++;
            $display("FAIL write_end got %b%b%b %h %h want 110 ff 0000", nDEVSEL, nWE, rsp_valid, D, A);
        end
    endtask

    task automatic test_read();
        int pulses = 0;
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = 16'hC400; cmd_we = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            cmd_valid = 1'b0;
            checks++;
            if ({nDEVSEL, nIOSEL, nIOSTRB, nWE} !== {1'b1, !(k >= 5 && k <= 7), 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL read_sel k=%0d got %b want %b", k, {nDEVSEL, nIOSEL, nIOSTRB, nWE},
                         {1'b1, !(k >= 5 && k <= 7), 2'b11});
            end
            checks++;
            if (rsp_valid !== (k == 8)) begin
                errors++;
                $display("FAIL read_latency k=%0d got %b want %b", k, rsp_valid, k == 8);
            end
            if (rsp_valid) pulses++;
            if (k == 8) begin
                checks++;
                if (rsp_rdata !== 8'hA7) begin
                    errors++;
                    $display("FAIL read_data got %h want a7", rsp_rdata);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL read_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        int cyc, ph;
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = 16'hC800; cmd_we = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 1)  cmd_addr = 16'hCFFF;
            if (k == 8)  cmd_addr = 16'h0000;
            if (k == 15) cmd_valid = 1'b0;
            cyc = (k - 1) / 7;
            ph  = (k - 1) % 7;
            exp_a = (cyc == 0) ? 16'hC800 : (cyc == 1) ? 16'hCFFF : 16'h0000;
            checks++;
            if ({A, nDEVSEL, nIOSEL, nIOSTRB} !== {exp_a, 1'b1, 1'b1, !(ph >= 4 && cyc < 2)}) begin
                errors++;
                $display("FAIL b2b_bus k=%0d got %h %b want %h %b", k, A, {nDEVSEL, nIOSEL, nIOSTRB},
                         exp_a, {2'b11, !(ph >= 4 && cyc < 2)});
            end
            checks++;
            if (rsp_valid !== (k == 8 || k == 15 || k == 22)) begin
                errors++;
                $display("FAIL b2b_rsp k=%0d got %b", k, rsp_valid);
            end
            if (k == 8 || k == 15 || k == 22) begin
                exp_d = (k == 8) ? 8'hAB : (k == 15) ? 8'h53 : 8'h63;
                checks++;
                if (rsp_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL b2b_data k=%0d got %h want %h", k, rsp_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset_midcycle();
        wait_ready();
        cmd_valid = 1'b1; cmd_addr = 16'hC0C0; cmd_we = 1'b1; cmd_wdata = 8'h3C;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if ({nDEVSEL, D} !== {1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL midres_pre got %b %h want 0 3c", nDEVSEL, D);
        end
        RES = 1'b1;
        tick();
        RES = 1'b0;
        checks++;
        if ({nDEVSEL, D, rsp_valid, nRES, nWE, A} !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL midres_post got %b %h %b%b%b %h want 1 ff 001 0000",
                     nDEVSEL, D, rsp_valid, nRES, nWE, A);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({rsp_valid, nRES, nDEVSEL} !== 3'b001) begin
                errors++;
                $display("FAIL midres_idle i=%0d got %b want 001", i, {rsp_valid, nRES, nDEVSEL});
            end
        end
    endtask

    task automatic test_cycle_length();
        int start = 0;
        int n = 0;
        int len, want;
        logic prev;
        do_reset(2);
        prev = PHI0;
        for (int i = 0; i < 1100 && n < 130; i++) begin
            tick();
            if (prev && !PHI0) begin
                len  = t - start;
                want = (LONG && (n % 65) == 64) ? 8 : 7;
                checks++;
                if (len != want) begin
                    errors++;
                    $display("FAIL cycle_len cycle=%0d got %0d want %0d", n, len, want);
                end
                start = t;
                n++;
            end
            prev = PHI0;
        end
        checks++;
        if (n != 130) begin
            errors++;
            $display("FAIL cycle_count got %0d want 130", n);
        end
    endtask

    task automatic test_random();
        logic        mflag [256];
        logic [7:0]  mval  [256];
        logic        cur_v, cur_we, acc, p_we, exp_rv, wr_now;
        logic [15:0] cur_addr, p_addr;
        logic [7:0]  cur_wd, p_wd, exp_rdata, idx, exp_d;
        logic [15:0] edges [6];
        int ph;
        edges[0] = 16'(32'hC07F + SLOT * 16); edges[1] = 16'(32'hC090 + SLOT * 16);
        edges[2] = 16'(32'hBFFF + SLOT * 256); edges[3] = 16'(32'hC100 + SLOT * 256);
        edges[4] = 16'hC7FF;                  edges[5] = 16'hCFFF;
        for (int i = 0; i < 256; i++) mflag[i] = 1'b0;
        do_reset(2);
        wait_ready();
        cur_v = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wd = '0;
        acc = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0; exp_rdata = '0;
        for (int i = 0; i < 800; i++) begin
            ph = phase_of(t);
            exp_rv = 1'b0;
            if (ph == 0) begin
                idx = cur_addr[7:0] ^ cur_addr[15:8];
                if (cur_v && !cur_we) begin
                    exp_rv    = 1'b1;
                    exp_rdata = mflag[idx] ? mval[idx] : (idx ^ 8'h63);
                end
                if (cur_v && cur_we) begin
                    mflag[idx] = 1'b1;
                    mval[idx]  = cur_wd;
                end
                cur_v    = acc;
                cur_we   = acc && p_we;
                cur_addr = acc ? p_addr : 16'h0000;
                cur_wd   = p_wd;
            end
            wr_now = cur_v && cur_we;
            checks++;
            if ({cmd_ready, PHI0, nRES, A, nWE} !== {ph == 6, ph >= 4, 1'b1, cur_addr, !wr_now}) begin
                errors++;
                $display("FAIL rand_bus t=%0d got %b%b%b %h %b want %b%b1 %h %b", t, cmd_ready, PHI0, nRES,
                         A, nWE, ph == 6, ph >= 4, cur_addr, !wr_now);
            end
            checks++;
            if ({nDEVSEL, nIOSEL, nIOSTRB} !== exp_sel(cur_addr, ph)) begin
                errors++;
                $display("FAIL rand_sel t=%0d a=%h got %b want %b", t, cur_addr,
                         {nDEVSEL, nIOSEL, nIOSTRB}, exp_sel(cur_addr, ph));
            end
            checks++;
            if ({rsp_valid, rsp_rdata} !== {exp_rv, exp_rdata}) begin
                errors++;
                $display("FAIL rand_rsp t=%0d got %b %h want %b %h", t, rsp_valid, rsp_rdata, exp_rv, exp_rdata);
            end
            if (wr_now || ph < 4) begin
                exp_d = (wr_now && ph >= 4) ? cur_wd : 8'hFF;
                checks++;
                if (D !== exp_d) begin
                    errors++;
                    $display("FAIL rand_d t=%0d got %h want %h", t, D, exp_d);
                end
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_wdata = 8'($urandom_range(0, 254));
            case ($urandom_range(0, 4))
                0:       cmd_addr = 16'(32'hC080 + SLOT * 16 + $urandom_range(0, 15));
                1:       cmd_addr = 16'(32'hC000 + SLOT * 256 + $urandom_range(0, 255));
                2:       cmd_addr = 16'(32'hC800 + $urandom_range(0, 2047));
                3:       cmd_addr = 16'($urandom_range(0, 65535));
                default: cmd_addr = edges[$urandom_range(0, 5)];
            endcase
            acc    = cmd_valid && (ph == 6);
            p_we   = cmd_we;
            p_addr = cmd_addr;
            p_wd   = cmd_wdata;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        RES = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_midcycle();
        test_cycle_length();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
